// File: rtl/es1_spu_op_nop_pkg.sv
// Shared types for the ES1 SPU operator delay pipeline.
package es1_spu_op_nop_pkg;

    // Control flags that travel alongside the data through every stage.
    typedef struct packed {
        logic clr;
        logic vld;
    } spu_flags_t;

endpackage

// File: rtl/es1_spu_op_nop_stage.sv
// One register stage of the operator delay pipeline: data plus clear/valid flags.
module es1_spu_op_nop_stage
    import es1_spu_op_nop_pkg::*;
#(
    parameter type   data_t     = logic [7:0],
    parameter data_t CLEAR_DATA = 'x,
    parameter        DEBUG      = "false"
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       cke,
    input  data_t      s_data,
    input  spu_flags_t s_flags,
    output data_t      m_data,
    output spu_flags_t m_flags
);

    data_t      data_q;
    spu_flags_t flags_q;
    data_t      data_d;
    spu_flags_t flags_d;

    // Next state: freeze on cke=0; clear beats valid; no valid means data holds.
    always_comb begin
        data_d  = data_q;
        flags_d = flags_q;
        if (cke) begin
            flags_d = s_flags;
            if (s_flags.clr)
                data_d = CLEAR_DATA;
            else if (s_flags.vld)
                data_d = s_data;
        end
    end

    // The debug variant only differs by the attribute on the stage registers.
    if (DEBUG == "true") begin : g_dbg
        (* mark_debug = "true" *) data_t      data_r;
        (* mark_debug = "true" *) spu_flags_t flags_r;

        // Stage register; reset overrides the clock enable.
        always_ff @(posedge clk) begin
            if (!reset) begin
                data_r  <= CLEAR_DATA;
                flags_r <= '0;
            end else begin
                data_r  <= data_d;
                flags_r <= flags_d;
            end
        end

        assign data_q  = data_r;
        assign flags_q = flags_r;
    end else begin : g_std
        data_t      data_r;
        spu_flags_t flags_r;

        // Stage register; reset overrides the clock enable.
        always_ff @(posedge clk) begin
            if (!reset) begin
                data_r  <= CLEAR_DATA;
                flags_r <= '0;
            end else begin
                data_r  <= data_d;
                flags_r <= flags_d;
            end
        end

        assign data_q  = data_r;
        assign flags_q = flags_r;
    end

    assign m_data  = data_q;
    assign m_flags = flags_q;

endmodule

// File: rtl/es1_spu_op_nop.sv
// Latency stage shared by the ES1 SPU operators: delays a combinational
// result by LATENCY cycles of cke, with clear and hold-on-invalid semantics.
module es1_spu_op_nop
    import es1_spu_op_nop_pkg::*;
#(
    parameter int    LATENCY    = 1,
    parameter int    DATA_BITS  = 8,
    parameter type   data_t     = logic [DATA_BITS-1:0],
    parameter data_t CLEAR_DATA = 'x,
    parameter        DEVICE     = "RTL",
    parameter        SIMULATION = "false",
    parameter        DEBUG      = "false"
) (
    input  logic  clk,
    input  logic  reset,
    input  logic  cke,
    input  data_t s_data,
    input  logic  s_clear,
    input  logic  s_valid,
    output data_t m_data
);

    if (DATA_BITS != $bits(data_t)) begin : g_bad_width
        $error("es1_spu_op_nop: DATA_BITS (%0d) differs from $bits(data_t) (%0d)",
               DATA_BITS, $bits(data_t));
    end

    if (LATENCY < 0) begin : g_bad_latency
        $error("es1_spu_op_nop: LATENCY must be >= 0, got %0d", LATENCY);
        assign m_data = CLEAR_DATA;
    end else if (LATENCY == 0) begin : g_bypass
        // Pure combinational path; clocking inputs and valid play no role here.
        assign m_data = s_clear ? CLEAR_DATA : s_data;

        logic unused_ok;
        assign unused_ok = ^{clk, reset, cke, s_valid};
    end else begin : g_pipe
        data_t      data_pipe [LATENCY+1];
        spu_flags_t flg_pipe  [LATENCY+1];

        assign data_pipe[0] = s_data;
        assign flg_pipe[0]  = '{clr: s_clear, vld: s_valid};

        for (genvar i = 0; i < LATENCY; i++) begin : g_stage
            es1_spu_op_nop_stage #(
                .data_t     (data_t),
                .CLEAR_DATA (CLEAR_DATA),
                .DEBUG      (DEBUG)
            ) u_stage (
                .clk     (clk),
                .reset   (reset),
                .cke     (cke),
                .s_data  (data_pipe[i]),
                .s_flags (flg_pipe[i]),
                .m_data  (data_pipe[i+1]),
                .m_flags (flg_pipe[i+1])
            );
        end

        assign m_data = data_pipe[LATENCY];

        // Flags leaving the last stage have no consumer.
        logic unused_ok;
        assign unused_ok = ^flg_pipe[LATENCY];
    end

endmodule

// File: tb/tb_es1_spu_op_nop.sv
// Self-checking bench: four latency variants share one input stream and are
// compared against a history-based reference model.
module tb_es1_spu_op_nop;

    logic       clk = 1'b0;
    logic       reset;
    logic       cke;
    logic [7:0] s_data;
    logic       s_clear;
    logic       s_valid;
    logic [7:0] m0, m1, m2, m3;

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    es1_spu_op_nop #(.LATENCY(0), .DATA_BITS(8), .CLEAR_DATA(8'hA5)) u_l0 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m0));
    es1_spu_op_nop #(.LATENCY(1), .DATA_BITS(8), .CLEAR_DATA(8'h00)) u_l1 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m1));
    es1_spu_op_nop #(.LATENCY(2), .DATA_BITS(8), .CLEAR_DATA(8'hA5)) u_l2 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m2));
    es1_spu_op_nop #(.LATENCY(3), .DATA_BITS(8), .CLEAR_DATA(8'h00)) u_l3 (
        .clk(clk), .reset(reset), .cke(cke), .s_data(s_data),
        .s_clear(s_clear), .s_valid(s_valid), .m_data(m3));

    // Reference: every input sampled on an enabled edge since the last reset.
    // A pipeline of depth n shows the fold of all samples at least n-1 edges old.
    typedef struct {
        logic       clr;
        logic       vld;
        logic [7:0] data;
    } smp_t;

    smp_t hist[$];

    function automatic logic [7:0] ref_out(int n, logic [7:0] clr_val);
        logic [7:0] v = clr_val;
        int lim = hist.size() - n + 1;
        for (int i = 0; i < lim; i++) begin
            if (hist[i].clr)      v = clr_val;
            else if (hist[i].vld) v = hist[i].data;
        end
        return v;
    endfunction

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %02h, expected %02h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // One clock with current inputs: check the bypass, clock, update model, check pipes.
    task automatic step();
        smp_t s;
        #1;
        chk("l0_comb", m0, s_clear ? 8'hA5 : s_data);
        @(posedge clk);
        if (!reset) begin
            hist.delete();
        end else if (cke) begin
            s.clr = s_clear; s.vld = s_valid; s.data = s_data;
            hist.push_back(s);
        end
        #1;
        chk("l1_model", m1, ref_out(1, 8'h00));
        chk("l2_model", m2, ref_out(2, 8'hA5));
        chk("l3_model", m3, ref_out(3, 8'h00));
    endtask

    task automatic drive(input logic [7:0] d, input logic clr, input logic vld, input logic en);
        s_data = d; s_clear = clr; s_valid = vld; cke = en;
    endtask

    initial begin
        reset = 1'b0;
        drive(8'h00, 1'b0, 1'b0, 1'b1);

        // Reset for two edges, then stream 1,2,3,... through all pipes.
        repeat (2) step();
        chk("l1_rst", m1, 8'h00);
        chk("l2_rst", m2, 8'hA5);
        chk("l3_rst", m3, 8'h00);
        reset = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            drive(8'(k), 1'b0, 1'b1, 1'b1);
            step();
            chk("l3_stream", m3, (k >= 3) ? 8'(k - 2) : 8'h00);
        end

        // Latency 1 follows the input one edge later.
        drive(8'h11, 1'b0, 1'b1, 1'b1); step(); chk("l1_11", m1, 8'h11);
        drive(8'h22, 1'b0, 1'b1, 1'b1); step(); chk("l1_22", m1, 8'h22);
        drive(8'h33, 1'b0, 1'b1, 1'b1); step(); chk("l1_33", m1, 8'h33);

        // Single clear pulse carrying 7F shows up as A5 on the 2-deep pipe, once.
        drive(8'h10, 1'b0, 1'b1, 1'b1); step();
        drive(8'h7F, 1'b1, 1'b1, 1'b1); step();
        drive(8'h20, 1'b0, 1'b1, 1'b1); step(); chk("l2_clr", m2, 8'hA5);
        drive(8'h21, 1'b0, 1'b1, 1'b1); step(); chk("l2_after_clr", m2, 8'h20);

        // Invalid beat between 01 and 02: output holds, EE never shows.
        drive(8'h01, 1'b0, 1'b1, 1'b1); step();
        drive(8'hEE, 1'b0, 1'b0, 1'b1); step(); chk("l2_gap_a", m2, 8'h01);
        drive(8'h02, 1'b0, 1'b1, 1'b1); step(); chk("l2_gap_b", m2, 8'h01);
        drive(8'h03, 1'b0, 1'b1, 1'b1); step(); chk("l2_gap_c", m2, 8'h02);

        // cke low for three edges mid-stream freezes everything.
        drive(8'h40, 1'b0, 1'b1, 1'b1); step();
        drive(8'h41, 1'b0, 1'b1, 1'b1); step();
        drive(8'h99, 1'b0, 1'b1, 1'b0);
        repeat (3) begin step(); chk("l2_frozen", m2, 8'h40); end
        drive(8'h42, 1'b0, 1'b1, 1'b1); step(); chk("l2_resume", m2, 8'h41);
        drive(8'h43, 1'b0, 1'b1, 1'b1); step(); chk("l2_resume2", m2, 8'h42);

        // Reset with cke low still flushes.
        drive(8'h55, 1'b0, 1'b1, 1'b0); reset = 1'b0; step();
        chk("l1_rst_cke0", m1, 8'h00);
        chk("l2_rst_cke0", m2, 8'hA5);
        reset = 1'b1;

        // Bypass path with no clock edge involved.
        drive(8'h5A, 1'b0, 1'b1, 1'b1); #1 chk("l0_5a", m0, 8'h5A);
        s_clear = 1'b1;                 #1 chk("l0_clr", m0, 8'hA5);

        // Randomized traffic with occasional mid-stream reset.
        for (int i = 0; i < 400; i++) begin
            reset = ($urandom_range(99) >= 3);
            drive(8'($urandom), ($urandom_range(9) == 0),
                  ($urandom_range(9) < 7), ($urandom_range(9) < 8));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
